// File: rtl/trace_pkg.sv
// Shared types for the trace buffer: FSM state encoding and the default
// packed vector layout (lane i lives in bits [i*DATA_WIDTH +: DATA_WIDTH]).
package trace_pkg;

  localparam int N_DEF          = 8;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic [1:0] {
    RECORD = 2'd0,
    FROZEN = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef logic [N_DEF-1:0][DATA_WIDTH_DEF-1:0] vector_t;

endpackage

// File: rtl/trace_mem.sv
// Simple dual-port trace RAM: one write port, one synchronous read port.
// No reset on storage or read register so it maps onto block RAM.
module trace_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_buffer.sv
// Circular trace capture behind dataPacker: record while tracing, freeze on
// request, then drain oldest-first over a valid/ready readout port.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tracing,
  input  logic                         valid_in,
  input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
  input  logic                         freeze,
  input  logic                         drain_req,
  input  logic                         out_ready,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
  output logic                         valid_out,
  output logic                         drain_done,
  output logic [CNT_W-1:0]             occupancy,
  output logic                         wrapped,
  output logic [1:0]                   state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int VEC_W = N * DATA_WIDTH;

  // Readout handshake: a beat transfers on a cycle where valid_out and
  // out_ready are both high; valid_out never drops and vector_out never
  // changes while a beat is waiting for out_ready.
  state_e             r_state;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_occ;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_wrapped;
  logic               r_valid_out;
  logic               r_drain_done;

  logic               w_capture;
  logic               w_rd_fire;
  logic               w_accept;
  logic [VEC_W-1:0]   w_rdata;

  assign w_capture = (r_state == RECORD) & valid_in & tracing;
  assign w_accept  = r_valid_out & out_ready;
  assign w_rd_fire = (r_state == DRAIN) & (r_remaining != '0) &
                     (!r_valid_out | out_ready);

  trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (VEC_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_capture),
    .i_waddr (r_wr_ptr),
    .i_wdata (vector_in),
    .i_re    (w_rd_fire),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RECORD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_remaining  <= '0;
      r_wrapped    <= 1'b0;
      r_valid_out  <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_drain_done <= 1'b0;
      case (r_state)
        RECORD: begin
          if (w_capture) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_occ == CNT_W'(DEPTH)) r_wrapped <= 1'b1;
            else                        r_occ     <= r_occ + 1'b1;
          end
          if (freeze) r_state <= FROZEN;
        end
        FROZEN: begin
          if (drain_req) begin
            if (r_occ == '0) begin
              r_drain_done <= 1'b1;
              r_state      <= RECORD;
            end else begin
              // Once wrapped, the slot about to be overwritten is the oldest.
              r_rd_ptr    <= r_wrapped ? r_wr_ptr : '0;
              r_remaining <= r_occ;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_rd_fire) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_valid_out <= 1'b1;
          end else if (w_accept && r_remaining == '0) begin
            r_valid_out  <= 1'b0;
            r_drain_done <= 1'b1;
            r_occ        <= '0;
            r_wr_ptr     <= '0;
            r_wrapped    <= 1'b0;
            r_state      <= RECORD;
          end
        end
        default: r_state <= RECORD;
      endcase
    end
  end

  // RAM read data is unreset, so the port shows zero whenever no beat is held.
  assign vector_out = r_valid_out ? w_rdata : '0;
  assign valid_out  = r_valid_out;
  assign drain_done = r_drain_done;
  assign occupancy  = r_occ;
  assign wrapped    = r_wrapped;
  assign state_o    = r_state;

endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer (N=4, DEPTH=8) with an expected-vector queue.
module tb_trace_buffer;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int VW    = N * DW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 tracing;
  logic                 valid_in;
  logic [N-1:0][DW-1:0] vector_in;
  logic                 freeze;
  logic                 drain_req;
  logic                 out_ready;
  logic [N-1:0][DW-1:0] vector_out;
  logic                 valid_out;
  logic                 drain_done;
  logic [CNT_W-1:0]     occupancy;
  logic                 wrapped;
  logic [1:0]           state_o;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] exp_q[$];
  bit            model_rec;
  int            first_valid_cyc, last_acc_cyc, done_cyc, done_count;
  int            hold_err, beats;

  trace_buffer #(.N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .freeze     (freeze),
    .drain_req  (drain_req),
    .out_ready  (out_ready),
    .vector_out (vector_out),
    .valid_out  (valid_out),
    .drain_done (drain_done),
    .occupancy  (occupancy),
    .wrapped    (wrapped),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return ((c - 1) % 3) == 0;
  endfunction

  task automatic capture(input logic [DW-1:0] lane0, input bit tr);
    logic [N-1:0][DW-1:0] v;
    v[0] = lane0;
    for (int i = 1; i < N; i++) v[i] = $urandom;
    vector_in = v;
    valid_in  = 1'b1;
    tracing   = tr;
    if (tr && model_rec) begin
      exp_q.push_back(v);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic do_freeze();
    freeze = 1'b1;
    tick();
    freeze    = 1'b0;
    model_rec = 1'b0;
  endtask

  // Issue drain_req, then pop and compare every accepted beat against exp_q.
  task automatic do_drain(input int mode, input int budget);
    logic          prev_stall;
    logic [VW-1:0] prev_vec;
    logic [VW-1:0] exp_v;
    first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    done_count = 0; hold_err = 0; beats = 0;
    prev_stall = 1'b0; prev_vec = '0;
    drain_req = 1'b1;
    out_ready = rdy(mode, 0);
    tick();
    drain_req = 1'b0;
    for (int c = 1; c < budget; c++) begin
      out_ready = rdy(mode, c);
      if (valid_out) begin
        if (first_valid_cyc < 0) first_valid_cyc = c;
        if (prev_stall && vector_out !== prev_vec) hold_err++;
        if (out_ready) begin
          beats++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL drain_extra_beat: got %h, expected no beat", vector_out);
          end else begin
            exp_v = exp_q.pop_front();
            if (vector_out !== exp_v) begin
              errors++;
              $display("FAIL drain_data: got %h, expected %h", vector_out, exp_v);
            end
          end
          last_acc_cyc = c;
          prev_stall   = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_vec   = vector_out;
        end
      end
      if (drain_done) begin
        done_count++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      tick();
    end
    out_ready = 1'b1;
    model_rec = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; vector_in = '0;
    freeze = 1'b0; drain_req = 1'b0; out_ready = 1'b1; model_rec = 1'b1;
    #12;
    checks++;
    if (state_o !== 2'd0 || occupancy !== '0 || wrapped !== 1'b0 ||
        valid_out !== 1'b0 || drain_done !== 1'b0 || vector_out !== '0) begin
      errors++;
      $display("FAIL reset_values: state=%0d occ=%0d wrap=%b vld=%b done=%b vec=%h, expected all zero",
               state_o, occupancy, wrapped, valid_out, drain_done, vector_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_drain();
    for (int i = 1; i <= 3; i++) capture(DW'(i), 1'b1);
    do_freeze();
    checks++;
    if (occupancy !== CNT_W'(3) || wrapped !== 1'b0 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL basic_pre_drain: occ=%0d wrap=%b state=%0d, expected 3 0 1", occupancy, wrapped, state_o);
    end
    do_drain(0, 20);
    checks++;
    if (first_valid_cyc !== 2) begin
      errors++;
      $display("FAIL basic_first_latency: got %0d, expected 2", first_valid_cyc);
    end
    checks++;
    if (beats !== 3 || last_acc_cyc !== 4) begin
      errors++;
      $display("FAIL basic_beats: beats=%0d last=%0d, expected 3 at cycle 4", beats, last_acc_cyc);
    end
    checks++;
    if (done_cyc !== last_acc_cyc + 1 || done_count !== 1) begin
      errors++;
      $display("FAIL basic_done: cyc=%0d count=%0d, expected %0d 1", done_cyc, done_count, last_acc_cyc + 1);
    end
    checks++;
    if (state_o !== 2'd0 || occupancy !== '0) begin
      errors++;
      $display("FAIL basic_post_state: state=%0d occ=%0d, expected 0 0", state_o, occupancy);
    end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 11; i++) capture(DW'(i), 1'b1);
    do_freeze();
    checks++;
    if (wrapped !== 1'b1 || occupancy !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL wrap_flags: wrap=%b occ=%0d, expected 1 %0d", wrapped, occupancy, DEPTH);
    end
    do_drain(0, 30);
    checks++;
    if (beats !== DEPTH || done_count !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL wrap_drain: beats=%0d done=%0d left=%0d, expected 8 1 0", beats, done_count, exp_q.size());
    end
    checks++;
    if (wrapped !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear: got %b, expected 0", wrapped);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < DEPTH; i++) capture(DW'(20 + i), 1'b1);
    do_freeze();
    do_drain(1, 80);
    checks++;
    if (hold_err !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable stalled cycles, expected 0", hold_err);
    end
    checks++;
    if (beats !== DEPTH || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_beats: beats=%0d left=%0d, expected 8 0", beats, exp_q.size());
    end
    checks++;
    if (done_cyc !== last_acc_cyc + 1 || done_count !== 1) begin
      errors++;
      $display("FAIL bp_done: cyc=%0d count=%0d, expected %0d 1", done_cyc, done_count, last_acc_cyc + 1);
    end
  endtask

  task automatic test_tracing_off();
    for (int i = 0; i < 5; i++) capture(DW'(100 + i), 1'b0);
    tracing = 1'b1;
    checks++;
    if (occupancy !== '0) begin
      errors++;
      $display("FAIL notrace_occ: got %0d, expected 0", occupancy);
    end
    do_freeze();
    do_drain(0, 10);
    checks++;
    if (first_valid_cyc !== -1 || done_cyc !== 1 || done_count !== 1) begin
      errors++;
      $display("FAIL notrace_drain: first=%0d done=%0d count=%0d, expected -1 1 1",
               first_valid_cyc, done_cyc, done_count);
    end
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL notrace_state: got %0d, expected 0", state_o);
    end
  endtask

  task automatic test_freeze_and_drain_same_cycle();
    logic [N-1:0][DW-1:0] v;
    v[0] = 32'h55; for (int i = 1; i < N; i++) v[i] = $urandom;
    vector_in = v; valid_in = 1'b1; tracing = 1'b1; freeze = 1'b1; drain_req = 1'b1;
    exp_q.push_back(v);
    tick();
    valid_in = 1'b0; freeze = 1'b0; drain_req = 1'b0; model_rec = 1'b0;
    checks++;
    if (state_o !== 2'd1 || occupancy !== CNT_W'(1)) begin
      errors++;
      $display("FAIL same_cycle_state: state=%0d occ=%0d, expected 1 1", state_o, occupancy);
    end
    for (int i = 0; i < 3; i++) capture(DW'(200 + i), 1'b1);
    checks++;
    if (occupancy !== CNT_W'(1) || state_o !== 2'd1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL frozen_ignores: occ=%0d state=%0d vld=%b, expected 1 1 0", occupancy, state_o, valid_out);
    end
    do_drain(0, 15);
    checks++;
    if (beats !== 1 || done_count !== 1) begin
      errors++;
      $display("FAIL same_cycle_drain: beats=%0d done=%0d, expected 1 1", beats, done_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [VW-1:0] exp_v;
    int acc;
    int dones;
    acc = 0; dones = 0;
    for (int i = 1; i <= 5; i++) capture(DW'(300 + i), 1'b1);
    do_freeze();
    drain_req = 1'b1; out_ready = 1'b1;
    tick();
    drain_req = 1'b0;
    for (int c = 1; c < 20 && acc < 2; c++) begin
      if (valid_out && out_ready) begin
        acc++;
        exp_v = exp_q.pop_front();
        checks++;
        if (vector_out !== exp_v) begin
          errors++;
          $display("FAIL rst_pre_beat: got %h, expected %h", vector_out, exp_v);
        end
      end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (acc !== 2 || valid_out !== 1'b0 || occupancy !== '0 || state_o !== 2'd0 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drain: acc=%0d vld=%b occ=%0d state=%0d done=%b, expected 2 0 0 0 0",
               acc, valid_out, occupancy, state_o, drain_done);
    end
    exp_q.delete();
    model_rec = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (drain_done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d pulses, expected 0", dones);
    end
    capture(DW'(777), 1'b1);
    do_freeze();
    do_drain(0, 15);
    checks++;
    if (beats !== 1 || done_count !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rst_after_capture: beats=%0d done=%0d left=%0d, expected 1 1 0",
               beats, done_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_wrap();
    test_backpressure();
    test_tracing_off();
    test_freeze_and_drain_same_cycle();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
